alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with single-cycle ops and a multi-cycle shift-add unsigned multiply.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic [DATA_W-1:0] i_data_1,
  input  logic [DATA_W-1:0] i_data_2,
  input  logic [DATA_W-1:0] i_im,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_alu_result,
  output logic              o_alu_ovflw,
  output logic              o_alu_illegal
);
  localparam int CW = $clog2(DATA_W);
  localparam int M  = DATA_W - 1;
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDU = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUBU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MULU = OP_W'(6);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(13);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, next;

  logic                accept, is_mul, last;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] prod, prod_next;
  logic [DATA_W:0]     psum, add_u, sub_u, addi_u;
  logic [DATA_W-1:0]   res;
  logic                ov, ill;

  assign o_ready = state == IDLE || (state == DONE && i_ready);
  assign o_valid = state == DONE;
  assign accept  = i_valid && o_ready;
  assign is_mul  = i_alu_op == OP_MULU;
  assign last    = cnt == CW'(DATA_W - 1);

  // Upper half accumulates the multiplicand; lower half holds the unconsumed multiplier bits.
  assign psum      = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {psum, prod[DATA_W-1:1]};

  assign add_u  = {1'b0, i_data_1} + {1'b0, i_data_2};
  assign sub_u  = {1'b0, i_data_1} - {1'b0, i_data_2};
  assign addi_u = {1'b0, i_data_1} + {1'b0, i_im};

  always_comb begin
    res = '0;
    ov  = 1'b0;
    ill = 1'b0;
    case (i_alu_op)
      OP_ADD:  begin res = add_u[M:0];  ov = i_data_1[M] == i_data_2[M] && add_u[M] != i_data_1[M]; end
      OP_SUB:  begin res = sub_u[M:0];  ov = i_data_1[M] != i_data_2[M] && sub_u[M] != i_data_1[M]; end
      OP_ADDU: begin res = add_u[M:0];  ov = add_u[DATA_W]; end
      OP_SUBU: begin res = sub_u[M:0];  ov = sub_u[DATA_W]; end
      OP_ADDI: begin res = addi_u[M:0]; ov = i_data_1[M] == i_im[M] && addi_u[M] != i_data_1[M]; end
      OP_MULU: ;
      OP_AND:  res = i_data_1 & i_data_2;
      OP_OR:   res = i_data_1 | i_data_2;
      OP_NOR:  res = ~(i_data_1 | i_data_2);
      OP_SLT:  res = {{M{1'b0}}, $signed(i_data_1) < $signed(i_data_2)};
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    next = state == MUL ? (last ? DONE : MUL) :
           accept       ? (is_mul ? MUL : DONE) :
           o_ready      ? IDLE : state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt           <= '0;
      mcand         <= '0;
      prod          <= '0;
      o_alu_result  <= '0;
      o_alu_ovflw   <= 1'b0;
      o_alu_illegal <= 1'b0;
    end else begin
      if (accept && is_mul) begin
        mcand <= i_data_1;
        prod  <= {{DATA_W{1'b0}}, i_data_2};
        cnt   <= '0;
      end else if (state == MUL) begin
        prod <= prod_next;
        cnt  <= last ? '0 : cnt + 1'b1;
      end
      if (accept && !is_mul) begin
        o_alu_result  <= res;
        o_alu_ovflw   <= ov;
        o_alu_illegal <= ill;
      end else if (state == MUL && last) begin
        o_alu_result  <= prod_next[DATA_W-1:0];
        o_alu_ovflw   <= |prod_next[2*DATA_W-1:DATA_W];
        o_alu_illegal <= 1'b0;
      end
    end
  end
endmodule
